// File: rtl/vpu_wb_queue.sv
// rtl/vpu_wb_queue.sv - VPU writeback FIFO between functional-unit results and the VRF write port.
// Optional macro VPU_WBQ_BYPASS_EN: empty queue forwards a result straight to the VRF port.
module vpu_wb_queue #(
   parameter int VLEN  = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       result_valid_i,
   output logic                       result_ready_o,
   input  logic [4:0]                 result_addr_i,
   input  logic [VLEN/8-1:0]          result_bweb_i,
   input  logic [VLEN-1:0]            result_data_i,
   output logic                       vrf_we_o,
   input  logic                       vrf_ready_i,
   output logic [4:0]                 vrf_addr_o,
   output logic [VLEN/8-1:0]          vrf_bweb_o,
   output logic [VLEN-1:0]            vrf_data_o,
   output logic [31:0]                pending_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]        r_addr [DEPTH];
   logic [VLEN/8-1:0] r_bweb [DEPTH];
   logic [VLEN-1:0]   r_data [DEPTH];
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_count;

   logic w_nonempty;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   // Distance of a slot from the read pointer; slots closer than count hold live entries.
   function automatic logic [CW-1:0] f_offset(input logic [PW-1:0] idx, input logic [PW-1:0] rd);
      logic [PW-1:0] d;
      d = idx - rd;
      return {1'b0, d};
   endfunction

   assign w_nonempty = (r_count != '0);

`ifdef VPU_WBQ_BYPASS_EN
   assign w_bypass = !rst && !w_nonempty && result_valid_i && vrf_ready_i && !flush_i;
`else
   assign w_bypass = 1'b0;
`endif

   // Readiness looks only at occupancy, so a full queue refuses even when popping.
   assign result_ready_o = (r_count < CW'(DEPTH)) && !flush_i;
   assign w_push         = result_valid_i && result_ready_o && !w_bypass;
   assign w_pop          = w_nonempty && vrf_ready_i;
   assign vrf_we_o       = w_nonempty || w_bypass;
   assign count_o        = r_count;

   always_comb begin
      vrf_addr_o = '0;
      vrf_bweb_o = '0;
      vrf_data_o = '0;
      if (w_bypass) begin
         vrf_addr_o = result_addr_i;
         vrf_bweb_o = result_bweb_i;
         vrf_data_o = result_data_i;
      end else if (w_nonempty) begin
         vrf_addr_o = r_addr[r_rd_ptr];
         vrf_bweb_o = r_bweb[r_rd_ptr];
         vrf_data_o = r_data[r_rd_ptr];
      end
   end

   always_comb begin
      pending_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (f_offset(PW'(i), r_rd_ptr) < r_count) begin
            pending_o[r_addr[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= result_addr_i;
         r_bweb[r_wr_ptr] <= result_bweb_i;
         r_data[r_wr_ptr] <= result_data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
